// File: rtl/multi_register_bank.sv
// -----------------------------------------------------------------------------
// multi_register_bank
//
// Bank of COUNT general-purpose WIDTH-bit registers that share one operation
// code and one data input. Each register has its own enable bit. The bank
// also provides two combinational read ports, per-register zero flags and a
// registered wrap flag.
//
// Ports:
//   Clock    in   1      rising-edge clock
//   Reset    in   1      asynchronous, active-low reset
//   I        in   WIDTH  shared data input
//   E        in   COUNT  enable mask; bit k enables register k
//   FunSel   in   3      operation code applied to every enabled register
//   OutASel  in   SELW   read port A select
//   OutBSel  in   SELW   read port B select
//   OutA     out  WIDTH  contents of R[OutASel], or 0 if the select is out of range
//   OutB     out  WIDTH  contents of R[OutBSel], or 0 if the select is out of range
//   Z        out  COUNT  Z[k] = 1 when register k holds 0
//   Wrap     out  1      set for one cycle after an enabled register wraps
// -----------------------------------------------------------------------------
module multi_register_bank #(
    parameter int               WIDTH       = 16,
    parameter int               COUNT       = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int               SELW        = (COUNT > 1) ? $clog2(COUNT) : 1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic [WIDTH-1:0] I,
    input  logic [COUNT-1:0] E,
    input  logic [2:0]       FunSel,
    input  logic [SELW-1:0]  OutASel,
    input  logic [SELW-1:0]  OutBSel,
    output logic [WIDTH-1:0] OutA,
    output logic [WIDTH-1:0] OutB,
    output logic [COUNT-1:0] Z,
    output logic             Wrap
);

    localparam int               H   = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    localparam logic [2:0] FS_DEC   = 3'b000;
    localparam logic [2:0] FS_INC   = 3'b001;
    localparam logic [2:0] FS_LOAD  = 3'b010;
    localparam logic [2:0] FS_CLR   = 3'b011;
    localparam logic [2:0] FS_LZEXT = 3'b100;
    localparam logic [2:0] FS_LLO   = 3'b101;
    localparam logic [2:0] FS_LHI   = 3'b110;
    localparam logic [2:0] FS_LSEXT = 3'b111;

    logic [WIDTH-1:0] regs_q [COUNT];
    logic [WIDTH-1:0] regs_d [COUNT];
    logic             wrap_q;
    logic             wrap_d;

    // Next value of one register for a given operation; q is that register's
    // own current value, so several enabled registers update independently.
    function automatic logic [WIDTH-1:0] next_val(input logic [2:0]       fs,
                                                   input logic [WIDTH-1:0] q,
                                                   input logic [WIDTH-1:0] d);
        logic [H-1:0] l;
        l = d[H-1:0];
        case (fs)
            FS_DEC:   next_val = q - ONE;
            FS_INC:   next_val = q + ONE;
            FS_LOAD:  next_val = d;
            FS_CLR:   next_val = '0;
            FS_LZEXT: next_val = {{H{1'b0}}, l};
            FS_LLO:   next_val = {q[WIDTH-1:H], l};
            FS_LHI:   next_val = {l, q[H-1:0]};
            default:  next_val = {{H{l[H-1]}}, l};
        endcase
    endfunction

    // A register wraps when it decrements from zero or increments from all-ones.
    function automatic logic wraps(input logic [2:0] fs, input logic [WIDTH-1:0] q);
        wraps = ((fs == FS_DEC) && (q == '0)) || ((fs == FS_INC) && (q == '1));
    endfunction

    always_comb begin
        wrap_d = 1'b0;
        for (int k = 0; k < COUNT; k++) begin
            regs_d[k] = regs_q[k];
            if (E[k]) begin
                regs_d[k] = next_val(FunSel, regs_q[k], I);
                if (wraps(FunSel, regs_q[k])) begin
                    wrap_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < COUNT; k++) begin
                regs_q[k] <= RESET_VALUE;
            end
            wrap_q <= 1'b0;
        end else begin
            for (int k = 0; k < COUNT; k++) begin
                regs_q[k] <= regs_d[k];
            end
            wrap_q <= wrap_d;
        end
    end

    // Read ports: a select that names no register reads as zero. No bypass
    // from regs_d, so a same-cycle write shows only after the edge.
    always_comb begin
        OutA = '0;
        OutB = '0;
        for (int k = 0; k < COUNT; k++) begin
            if (OutASel == SELW'(k)) begin
                OutA = regs_q[k];
            end
            if (OutBSel == SELW'(k)) begin
                OutB = regs_q[k];
            end
        end
    end

    always_comb begin
        for (int k = 0; k < COUNT; k++) begin
            Z[k] = (regs_q[k] == '0);
        end
    end

    assign Wrap = wrap_q;

endmodule
